// File: rtl/stage_sequencer.sv
// stage_sequencer: single-clock phase sequencer for the nonpipelined LEGv8 datapath.
// Each instruction is split into NUM_PHASES phases. Phase i drives a one-hot clock enable to
// stage i on the common clk. The block supports stall, graceful halt at an instruction
// boundary and an optional instruction budget. It also keeps saturating instruction and
// cycle counters.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset; clears all state
//   start        begin/resume sequencing from IDLE or HALTED (level)
//   stall        freeze phase advance for the current cycle
//   halt_req     request stop at the next instruction boundary
//   phase_en     one-hot stage enable, zero when not advancing
//   instr_done   high during the last (non-stalled) phase of an instruction
//   instr_count  completed instructions, saturating
//   cycle_count  cycles spent in RUN/HALTING, saturating
//   running      state is RUN or HALTING
//   halted       state is HALTED
module stage_sequencer #(
  parameter int unsigned NUM_PHASES = 5,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned MAX_INSTR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  halt_req,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic                  instr_done,
  output logic [CNT_WIDTH-1:0]  instr_count,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic                  running,
  output logic                  halted
);

  localparam int unsigned    IdxW    = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_PHASES - 1);
  // Wide enough to compare the counter against the 32-bit budget without truncating either.
  localparam int unsigned    CmpW    = CNT_WIDTH + 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalting,
    StHalted
  } state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [CNT_WIDTH-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;

  logic advance;
  logic complete;
  logic budget_hit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign running    = (state_q == StRun) || (state_q == StHalting);
  assign halted     = (state_q == StHalted);
  assign advance    = running && !stall;
  assign complete   = advance && (idx_q == LastIdx);
  assign phase_en   = advance ? (NUM_PHASES'(1) << idx_q) : '0;
  assign instr_done = phase_en[NUM_PHASES-1];

  assign instr_count = instr_cnt_q;
  assign cycle_count = cycle_cnt_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    instr_cnt_d = instr_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    budget_hit  = 1'b0;

    if (running) begin
      cycle_cnt_d = sat_inc(cycle_cnt_q);
    end
    if (advance) begin
      idx_d = complete ? '0 : idx_q + 1'b1;
    end
    if (complete) begin
      instr_cnt_d = sat_inc(instr_cnt_q);
    end

    // Budget is checked against the post-increment count so a resume from HALTED after the
    // budget is exhausted runs exactly one more instruction.
    if ((MAX_INSTR != 0) && complete && (CmpW'(instr_cnt_d) >= CmpW'(MAX_INSTR))) begin
      budget_hit = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          idx_d   = '0;
        end
      end
      StRun: begin
        if (halt_req) begin
          state_d = complete ? StHalted : StHalting;
        end
      end
      StHalting: begin
        if (complete) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (start) begin
          state_d = StRun;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase

    // idx_d is already zero here because the budget only fires on a completing edge.
    if (budget_hit) begin
      state_d = StHalted;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Single-clock replacement for the multi-phase delayed-clock scheme that drives the nonpipelined LEGv8 datapath stages.
- Generates one-hot per-stage phase enables for fetch, decode read, execute/memory, memory and decode write in a parametrised sequence.
- Supports stall, graceful halt and an instruction budget, and keeps instruction/cycle performance counters.
- Sits at the top of the datapath. Stages consume phase_en[i] as clock enables on the common clk.

Parameters:
NUM_PHASES, 5, number of phases per instruction (>=2); phase i enables stage i
CNT_WIDTH, 32, width of instr_count and cycle_count
MAX_INSTR, 0, instruction budget; auto-halt after this many completed instructions; 0 = unlimited

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  begin/resume sequencing (level, sampled at clk edge)
stall  input  1  freeze phase advance for this cycle
halt_req  input  1  request stop at next instruction boundary
phase_en  output  NUM_PHASES  one-hot stage enable; all-zero when not advancing
instr_done  output  1  high during the last phase of an instruction (non-stalled)
instr_count  output  CNT_WIDTH  completed instructions, saturating
cycle_count  output  CNT_WIDTH  clk cycles spent in RUN/HALTING, saturating
running  output  1  state is RUN or HALTING
halted  output  1  state is HALTED

Behaviour:
- Reset behaviour:
  - reset=1 immediately forces state=IDLE and phase index=0.
  - All outputs go to 0: phase_en=0, instr_done=0, instr_count=0, cycle_count=0, running=0, halted=0.
  - This holds regardless of clk, including mid-instruction.
- Phase index is a registered counter of width $clog2(NUM_PHASES).
- Combinational outputs:
  - phase_en = (running && !stall) ? (1 << idx) : 0.
  - instr_done = phase_en[NUM_PHASES-1].
- States:
  - IDLE: start=1 → RUN, idx=0. First phase_en[0] appears in the cycle after the edge that samples start. halt_req is ignored.
  - RUN:
    - Each non-stalled cycle, idx+1. At idx=NUM_PHASES-1, idx wraps to 0 and instr_count increments (saturating).
    - halt_req=1 → HALTING, unless that same edge completes an instruction; then → HALTED directly.
    - start is ignored.
  - HALTING: sequencing continues (stall still honoured) until the edge completing the last phase, then → HALTED with idx=0. halt_req deassertion does not cancel the halt.
  - HALTED: phase_en=0. start=1 → RUN at idx=0. Counters are retained, not cleared.
- Budget: with MAX_INSTR≠0, the edge at which instr_count becomes MAX_INSTR forces → HALTED. This takes priority over everything except reset.
  - A later start in HALTED runs exactly one more instruction, because the budget check triggers on the next completion (instr_count ≥ MAX_INSTR).
- Stall:
  - stall=1 → phase_en=0 and idx held. No instruction completes on that cycle.
  - cycle_count still increments.
  - Stall in IDLE/HALTED has no effect.
- cycle_count increments on every edge where running=1 (saturating at all-ones).
- Simultaneous events at one edge:
  - Completion + halt_req → HALTED.
  - Completion + budget hit → HALTED.
  - Stall + halt_req → HALTING; the halt is not completed that cycle.
- Saturation: both counters stick at 2^CNT_WIDTH-1 and never wrap. Sequencing continues normally.

Test Plan:
- Reset, start pulse, NUM_PHASES=5, no stall for 10 cycles → phase_en 00001,00010,00100,01000,10000 repeating. instr_done high in cycles 5 and 10. instr_count=2, cycle_count=10.
- Stall held 3 cycles while phase_en=00100 → phase_en=0 for 3 cycles, then resumes at 00100. instr_count unaffected. cycle_count +3.
- halt_req pulsed at phase 1 of instruction 3 → phases 2–4 still issued. halted=1 after the edge completing instruction 3. instr_count=3, phase_en=0 thereafter. start → resumes at 00001 with instr_count retained.
- MAX_INSTR=4, continuous run → halted=1 exactly after the 4th instr_done. instr_count=4, running=0.
- Async reset asserted mid-phase 2 (between edges) → all outputs 0 immediately, without waiting for clk. After release with start low, stays IDLE with phase_en=0.
- CNT_WIDTH=4, run 20 instructions at NUM_PHASES=2 → instr_count saturates at 15, cycle_count at 15. phase_en keeps toggling 01/10.
